hazard_unit_mc: RTL and testbench
=================================

# hazard_unit_mc

Pipeline hazard controller for the five-stage RISC-V core with support for multi-cycle execute operations and configurable load-use latency. It generates stall, flush and forwarding controls for all stages. Two internal counters/FSMs hold the front end for parameterised numbers of cycles: one while a long operation (mul/div) occupies Execute, and one while a load result is not yet forwardable. Branch-predictor and instruction-cache interaction is unchanged from the current single-cycle hazard unit.

## Interface
- REG_AW, 5: register address width.
- MUL_LAT, 4: cycles a long op occupies Execute (≥1; 1 means no hold).
- LOAD_LAT, 1: load-use bubbles inserted (≥1).
- clk  in  1  clock. One clock; all state updates on its rising edge.
- reset  in  1  reset. Synchronous, active-high.
- InstrMissF  in  1  I-cache miss; global pipeline freeze.
- Rs1D, Rs2D  in  REG_AW  Decode source registers.
- Rs1E, Rs2E, RdE  in  REG_AW  Execute source and destination registers.
- ResultSrcEb2  in  1  Execute instruction is a load.
- LongOpE  in  1  Execute instruction is a multi-cycle op.
- PCSrcb1  in  1  Execute-stage redirect taken.
- PCSrcReg  in  2  registered PC-source; bit 1 means mispredict recovery.
- InstrCacheRepActive  in  1  I-cache line replacement in progress.
- RdM, RegWriteM  in  REG_AW, 1  Memory-stage destination and write enable.
- RdW, RegWriteW  in  REG_AW, 1  Writeback-stage destination and write enable.
- StallF, StallD, StallE, StallM, StallW  out  1  stage holds.
- FlushD, FlushE, FlushM  out  1  bubble insertion into D, E, M.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = W, 10 = M.
- LongBusyE  out  1  long op is being held in Execute.

## Operation
- Forwarding (combinational): for each source X, ForwardXE is 10 if RsXE==RdM & RegWriteM & RsXE!=0; otherwise 01 if RsXE==RdW & RegWriteW & RsXE!=0; otherwise 00.
- LoadDetect = ResultSrcEb2 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE). The x0 exclusion is new.
- Load counter ldcnt (width sized for LOAD_LAT):
  - If LoadDetect & ldcnt==0, then ldcnt loads LOAD_LAT-1.
  - If ldcnt!=0, ldcnt decrements.
  - LoadHold = LoadDetect | ldcnt!=0. This gives exactly LOAD_LAT hold cycles.
- Long FSM, states IDLE and BUSY, with counter lcnt:
  - IDLE & LongOpE & MUL_LAT>1: LongHold=1; next state BUSY, lcnt=MUL_LAT-2.
  - BUSY & lcnt!=0: LongHold=1; lcnt decrements.
  - BUSY & lcnt==0: LongHold=0; next state IDLE. The op advances to M this cycle.
  - LongBusyE = LongHold.
- Outputs:
  - StallF = (LoadHold | LongHold | InstrMissF) & ~PCSrcReg[1].
  - StallD = LoadHold | LongHold | InstrMissF.
  - StallE = LongHold | InstrMissF.
  - StallM = StallW = InstrMissF.
  - FlushD = PCSrcb1.
  - FlushE = (PCSrcb1 & (InstrCacheRepActive | PCSrcReg[1])) | (LoadHold & ~LongHold).
  - FlushM = LongHold & ~InstrMissF.
- Freeze: while InstrMissF=1, ldcnt, lcnt and the FSM state hold their values, and LoadDetect does not load ldcnt.
- Exclusivity: LongOpE and ResultSrcEb2 are never both 1 (same instruction). If they are, the long FSM has priority and ldcnt is not loaded.

## Timing
- Reset: state IDLE, ldcnt=0, lcnt=0. All stall and flush outputs are 0 and ForwardXE=00 when inputs are idle/zero.
- Forwarding, LoadDetect and all outputs are combinational from inputs and current state. Counters update at the clk edge.
- Long op issued at cycle t, MUL_LAT=N>1:
  - LongHold is 1 for cycles t..t+N-2.
  - The op leaves E at the edge ending cycle t+N-1.
  - M receives N-1 bubbles.
- A load in E at cycle t with a dependent instruction in D: LoadHold is 1 for cycles t..t+LOAD_LAT-1. E receives LOAD_LAT bubbles.
- Reset asserted mid-operation: next cycle returns to IDLE with counters 0. No residual hold.
- Back-to-back long ops: the second op enters E after the release cycle and starts a fresh count from IDLE.

## Test plan
- Forward priority: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. With RegWriteM=0 -> 01. With Rs1E=0 -> 00.
- Load-use, LOAD_LAT=1 and 3: load RdE=7, Rs2D=7 -> StallF/StallD/FlushE high for exactly 1 and 3 cycles respectively. RdE=0 -> no stall.
- Long op, MUL_LAT=4: LongOpE at cycle 10 -> StallE/StallD/StallF/FlushM/LongBusyE high for cycles 10-12, low at 13. A second LongOpE at 14 -> high for cycles 14-16.
- Freeze: InstrMissF pulsed for 2 cycles during a long op's second hold cycle -> hold extended by 2 cycles, StallM/StallW high, FlushM low during the freeze.
- Branch recovery: PCSrcb1=1, PCSrcReg=2'b10, plus LoadDetect -> FlushD=1, FlushE=1, StallF=0.
- Reset mid-op: reset at hold cycle 2 of MUL_LAT=6 -> all stalls 0 on the next cycle. A following LongOpE restarts a full 5-cycle hold.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: pipeline hazard controller for the five-stage RISC-V core.
// Generates per-stage stall/flush controls and Execute-stage forwarding selects.
// Two hold mechanisms freeze the front end:
//   - a long-op FSM (IDLE/BUSY + lcnt) keeps a mul/div in Execute for MUL_LAT cycles
//   - a load counter (ldcnt) inserts LOAD_LAT bubbles behind a load-use dependency
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   InstrMissF                  I-cache miss, freezes the whole pipeline and both counters
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE    Decode and Execute register addresses
//   ResultSrcEb2, LongOpE       Execute instruction is a load / a multi-cycle op
//   PCSrcb1, PCSrcReg           redirect taken / registered PC source (bit 1 = mispredict recovery)
//   InstrCacheRepActive         I-cache line replacement in progress
//   RdM/RegWriteM, RdW/RegWriteW  later-stage destinations for forwarding
//   Stall{F,D,E,M,W}, Flush{D,E,M}, Forward{A,B}E, LongBusyE  controls out
module hazard_unit_mc #(
  parameter int REG_AW   = 5,
  parameter int MUL_LAT  = 4,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InstrMissF,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              ResultSrcEb2,
  input  logic              LongOpE,
  input  logic              PCSrcb1,
  input  logic [1:0]        PCSrcReg,
  input  logic              InstrCacheRepActive,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              LongBusyE
);

  localparam int LDW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int LCW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [LDW-1:0] LD_INIT = LDW'((LOAD_LAT > 1) ? LOAD_LAT - 1 : 0);
  localparam logic [LCW-1:0] LC_INIT = LCW'((MUL_LAT > 2) ? MUL_LAT - 2 : 0);
  localparam logic           LONG_EN = (MUL_LAT > 1);

  typedef enum logic {IDLE, BUSY} long_state_t;

  long_state_t    state_q, state_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;
  logic [LDW-1:0] ldcnt_q, ldcnt_d;

  logic load_detect;
  logic long_start;
  logic long_hold;
  logic load_hold;
  logic pcsrc_unused;

  assign pcsrc_unused = PCSrcReg[0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lcnt_q  <= '0;
      ldcnt_q <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      ldcnt_q <= ldcnt_d;
    end
  end

  always_comb begin
    load_detect = ResultSrcEb2 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    long_start  = (state_q == IDLE) && LongOpE && LONG_EN;
  end

  // Next-state: everything holds during an I-cache miss. A long op in Execute
  // suppresses the ldcnt load so the two holds never start together.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    ldcnt_d = ldcnt_q;
    if (!InstrMissF) begin
      case (state_q)
        IDLE: begin
          if (long_start) begin
            state_d = BUSY;
            lcnt_d  = LC_INIT;
          end
        end
        BUSY: begin
          if (lcnt_q != '0) lcnt_d = lcnt_q - LCW'(1);
          else              state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (ldcnt_q != '0)                 ldcnt_d = ldcnt_q - LDW'(1);
      else if (load_detect && !LongOpE)  ldcnt_d = LD_INIT;
    end
  end

  // Outputs
  always_comb begin
    long_hold = long_start || ((state_q == BUSY) && (lcnt_q != '0));
    load_hold = load_detect || (ldcnt_q != '0);

    StallD    = load_hold || long_hold || InstrMissF;
    StallF    = StallD && !PCSrcReg[1];
    StallE    = long_hold || InstrMissF;
    StallM    = InstrMissF;
    StallW    = InstrMissF;
    FlushD    = PCSrcb1;
    FlushE    = (PCSrcb1 && (InstrCacheRepActive || PCSrcReg[1])) || (load_hold && !long_hold);
    FlushM    = long_hold && !InstrMissF;
    LongBusyE = long_hold;

    ForwardAE = 2'b00;
    if (RegWriteM && (Rs1E == RdM) && (Rs1E != '0))      ForwardAE = 2'b10;
    else if (RegWriteW && (Rs1E == RdW) && (Rs1E != '0)) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && (Rs2E == RdM) && (Rs2E != '0))      ForwardBE = 2'b10;
    else if (RegWriteW && (Rs2E == RdW) && (Rs2E != '0)) ForwardBE = 2'b01;
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic       InstrMissF;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcEb2, LongOpE, PCSrcb1, InstrCacheRepActive, RegWriteM, RegWriteW;
  logic [1:0] PCSrcReg;

  // Packed outputs: {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,FlushM,FwdA[1:0],FwdB[1:0],LongBusyE}
  logic [12:0] o0, o1;
  localparam int SF = 12, SD = 11, SE = 10, SM = 9, SW = 8, FD = 7, FE = 6, FM = 5, LB = 0;

  int total = 0;
  int bad   = 0;

  // Reference model state: remaining cycles the long op occupies E, remaining load bubbles
  int mlat[2]  = '{4, 6};
  int llat[2]  = '{1, 3};
  int lrem[2]  = '{0, 0};
  int ldrem[2] = '{0, 0};

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MUL_LAT(4), .LOAD_LAT(1)) u0 (
    .clk(clk), .reset(reset), .InstrMissF(InstrMissF),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcEb2(ResultSrcEb2), .LongOpE(LongOpE), .PCSrcb1(PCSrcb1), .PCSrcReg(PCSrcReg),
    .InstrCacheRepActive(InstrCacheRepActive), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(o0[12]), .StallD(o0[11]), .StallE(o0[10]), .StallM(o0[9]), .StallW(o0[8]),
    .FlushD(o0[7]), .FlushE(o0[6]), .FlushM(o0[5]), .ForwardAE(o0[4:3]), .ForwardBE(o0[2:1]),
    .LongBusyE(o0[0])
  );

  hazard_unit_mc #(.REG_AW(5), .MUL_LAT(6), .LOAD_LAT(3)) u1 (
    .clk(clk), .reset(reset), .InstrMissF(InstrMissF),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcEb2(ResultSrcEb2), .LongOpE(LongOpE), .PCSrcb1(PCSrcb1), .PCSrcReg(PCSrcReg),
    .InstrCacheRepActive(InstrCacheRepActive), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(o1[12]), .StallD(o1[11]), .StallE(o1[10]), .StallM(o1[9]), .StallW(o1[8]),
    .FlushD(o1[7]), .FlushE(o1[6]), .FlushM(o1[5]), .ForwardAE(o1[4:3]), .ForwardBE(o1[2:1]),
    .LongBusyE(o1[0])
  );

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (rs != 0 && RegWriteM && rs == RdM) return 2'b10;
    if (rs != 0 && RegWriteW && rs == RdW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic detect();
    return ResultSrcEb2 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
  endfunction

  function automatic logic [12:0] expect_out(input int k);
    logic lh, ldh, sd;
    lh  = (lrem[k] == 0) ? (LongOpE && mlat[k] > 1) : (lrem[k] > 1);
    ldh = detect() || ldrem[k] > 0;
    sd  = ldh || lh || InstrMissF;
    return {sd && !PCSrcReg[1], sd, lh || InstrMissF, InstrMissF, InstrMissF,
            PCSrcb1, (PCSrcb1 && (InstrCacheRepActive || PCSrcReg[1])) || (ldh && !lh),
            lh && !InstrMissF, fwd(Rs1E), fwd(Rs2E), lh};
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        lrem[k]  = 0;
        ldrem[k] = 0;
      end else if (!InstrMissF) begin
        if (lrem[k] == 0 && LongOpE && mlat[k] > 1) lrem[k] = mlat[k] - 1;
        else if (lrem[k] > 0)                         lrem[k]--;
        if (ldrem[k] > 0)                      ldrem[k]--;
        else if (detect() && !LongOpE)         ldrem[k] = llat[k] - 1;
      end
    end
  endtask

  // Called just after a negedge with inputs set: compare, clock, advance model.
  task automatic cyc();
    #1;
    chk("model_u0", o0, expect_out(0));
    chk("model_u1", o1, expect_out(1));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; InstrMissF = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    RdM = 0; RdW = 0; ResultSrcEb2 = 0; LongOpE = 0; PCSrcb1 = 0; PCSrcReg = 0;
    InstrCacheRepActive = 0; RegWriteM = 0; RegWriteW = 0;
  endtask

  typedef struct {
    logic [4:0] rs1e, rs2e, rdm;
    logic       rwm;
    logic [4:0] rdw;
    logic       rww;
    logic [1:0] fa, fb;
  } fvec_t;

  fvec_t fv[6];

  initial begin
    fv[0] = '{rs1e: 5,  rs2e: 9,  rdm: 5,  rwm: 1, rdw: 5,  rww: 1, fa: 2'b10, fb: 2'b00};
    fv[1] = '{rs1e: 5,  rs2e: 5,  rdm: 5,  rwm: 0, rdw: 5,  rww: 1, fa: 2'b01, fb: 2'b01};
    fv[2] = '{rs1e: 0,  rs2e: 0,  rdm: 0,  rwm: 1, rdw: 0,  rww: 1, fa: 2'b00, fb: 2'b00};
    fv[3] = '{rs1e: 3,  rs2e: 4,  rdm: 4,  rwm: 1, rdw: 3,  rww: 1, fa: 2'b01, fb: 2'b10};
    fv[4] = '{rs1e: 3,  rs2e: 4,  rdm: 3,  rwm: 1, rdw: 4,  rww: 0, fa: 2'b10, fb: 2'b00};
    fv[5] = '{rs1e: 31, rs2e: 31, rdm: 30, rwm: 1, rdw: 31, rww: 1, fa: 2'b01, fb: 2'b01};

    idle_inputs();
    reset = 1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset = 0;
    #1;
    chk("reset_u0", o0, 13'h0);
    chk("reset_u1", o1, 13'h0);
    cyc();

    // Forwarding table
    foreach (fv[i]) begin
      Rs1E = fv[i].rs1e; Rs2E = fv[i].rs2e; RdM = fv[i].rdm; RegWriteM = fv[i].rwm;
      RdW = fv[i].rdw; RegWriteW = fv[i].rww;
      #1;
      chk("fwdA_u0", 13'(o0[4:3]), 13'(fv[i].fa));
      chk("fwdB_u0", 13'(o0[2:1]), 13'(fv[i].fb));
      chk("fwdA_u1", 13'(o1[4:3]), 13'(fv[i].fa));
      cyc();
    end
    idle_inputs();

    // Load-use: one-cycle load with dependent Rs2D
    ResultSrcEb2 = 1; RdE = 7; Rs2D = 7;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ld_stallD_u0", 13'(o0[SD]), 13'(i < 1));
      chk("ld_stallF_u1", 13'(o1[SF]), 13'(i < 3));
      chk("ld_flushE_u1", 13'(o1[FE]), 13'(i < 3));
      cyc();
      idle_inputs();
    end
    ResultSrcEb2 = 1; RdE = 0;
    #1;
    chk("ld_x0_u1", 13'(o1[SD]), 13'h0);
    cyc();
    idle_inputs();

    // Long ops: one at i=0, a second at i=4 (u1 still busy then, so it ignores it)
    for (int i = 0; i < 9; i++) begin
      LongOpE = (i == 0 || i == 4);
      #1;
      chk("long_busy_u0", 13'(o0[LB]), 13'(i < 3 || (i >= 4 && i < 7)));
      chk("long_stallE_u0", 13'(o0[SE]), 13'(i < 3 || (i >= 4 && i < 7)));
      chk("long_flushM_u0", 13'(o0[FM]), 13'(i < 3 || (i >= 4 && i < 7)));
      chk("long_busy_u1", 13'(o1[LB]), 13'(i < 5));
      cyc();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) cyc();

    // Freeze during the second hold cycle
    for (int i = 0; i < 9; i++) begin
      LongOpE = (i == 0);
      InstrMissF = (i == 1 || i == 2);
      #1;
      chk("frz_busy_u0", 13'(o0[LB]), 13'(i < 5));
      chk("frz_stallM_u0", 13'(o0[SM]), 13'(i == 1 || i == 2));
      chk("frz_stallW_u0", 13'(o0[SW]), 13'(i == 1 || i == 2));
      chk("frz_flushM_u0", 13'(o0[FM]), 13'(i == 0 || i == 3 || i == 4));
      chk("frz_busy_u1", 13'(o1[LB]), 13'(i < 7));
      cyc();
    end
    idle_inputs();

    // Branch recovery with a load-use present
    PCSrcb1 = 1; PCSrcReg = 2'b10; ResultSrcEb2 = 1; RdE = 7; Rs1D = 7;
    #1;
    chk("br_flushD", 13'(o0[FD]), 13'h1);
    chk("br_flushE", 13'(o0[FE]), 13'h1);
    chk("br_stallF", 13'(o0[SF]), 13'h0);
    cyc();
    idle_inputs();
    for (int i = 0; i < 3; i++) cyc();

    // Reset mid-op on u1 (MUL_LAT=6), then a full 5-cycle hold
    for (int i = 0; i < 10; i++) begin
      LongOpE = (i == 0 || i == 3);
      reset = (i == 1);
      #1;
      if (i == 1) chk("rst_pre_u1", 13'(o1[LB]), 13'h1);
      if (i == 2) begin
        chk("rst_after_u1", 13'(o1[SD]), 13'h0);
        chk("rst_after_u0", 13'(o0[SD]), 13'h0);
      end
      if (i >= 3) chk("rst_restart_u1", 13'(o1[LB]), 13'(i < 8));
      cyc();
    end
    idle_inputs();

    // Randomized against the model
    for (int n = 0; n < 600; n++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      LongOpE = ($urandom_range(0, 7) == 0);
      ResultSrcEb2 = !LongOpE && ($urandom_range(0, 2) == 0);
      InstrMissF = ($urandom_range(0, 9) == 0);
      PCSrcb1 = ($urandom_range(0, 3) == 0);
      PCSrcReg = 2'($urandom_range(0, 3));
      InstrCacheRepActive = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 59) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
